// File: rtl/fir_io_pkg.sv
// Shared types and defaults for the FIR result serializer: transmit FSM encoding,
// default widths/depths and the FIFO pointer-width helper.
package fir_io_pkg;

    localparam int DATA_W_DEF      = 16;
    localparam int BYTE_W_DEF      = 8;
    localparam int FIFO_DEPTH_DEF  = 4;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_REQ   = 2'd2,
        ST_REL   = 2'd3
    } tx_state_e;

    // Pointer width for a power-of-two FIFO; the level counter is one bit wider.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Single-clock sample FIFO with registered storage, full/empty flags and an
// occupancy count. Pointers wrap naturally because DEPTH is a power of two.
module fir_sync_fifo
    import fir_io_pkg::*;
#(
    parameter int WIDTH = DATA_W_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF,
    localparam int PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W:0]   level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (level_q == (PTR_W + 1)'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (PTR_W + 1)'(1);
            2'b01:   level_d = level_q - (PTR_W + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/fir_out_serializer.sv
// Buffers 16-bit FIR results and ships each one to the host as two bytes (high first)
// over a 4-phase req/ack handshake whose acknowledge is synchronized internally.
module fir_out_serializer
    import fir_io_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int BYTE_W      = BYTE_W_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_W-1:0]           s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [BYTE_W-1:0]           tx_byte,
    output logic                        tx_req,
    input  logic                        tx_ack,
    output logic                        tx_hi,
    output logic [ptr_w(FIFO_DEPTH):0]  fifo_level,
    output logic                        overflow,
    input  logic                        clr_ovf,
    output logic [1:0]                  dbg_state
);

    // Handshake: s_data is taken on a rising edge where s_valid && s_ready.
    // Host side: tx_byte/tx_hi are stable before tx_req rises and while it is high;
    // the host raises tx_ack, we drop tx_req, the host drops tx_ack, then the next byte.

    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   ack_s;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic [DATA_W-1:0]      fifo_rd_data;

    tx_state_e              state_q, state_d;
    logic                   tx_req_q, tx_req_d;
    logic [BYTE_W-1:0]      tx_byte_q, tx_byte_d;
    logic                   tx_hi_q, tx_hi_d;
    logic                   sel_q, sel_d;
    logic [DATA_W-1:0]      hold_q, hold_d;
    logic                   overflow_q, overflow_d;

    assign fifo_push = s_valid && !fifo_full;
    assign s_ready   = !fifo_full;

    fir_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (fifo_push),
        .wr_data_i (s_data),
        .pop_i     (fifo_pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], tx_ack};
        end
    end

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    // Set has priority over clear so a drop in the clearing cycle is not lost.
    always_comb begin
        overflow_d = overflow_q;
        if (s_valid && fifo_full) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_req_d  = tx_req_q;
        tx_byte_d = tx_byte_q;
        tx_hi_d   = tx_hi_q;
        sel_d     = sel_q;
        hold_d    = hold_q;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A host still holding ack from an earlier exchange must release it first.
                if (!fifo_empty && !ack_s) begin
                    fifo_pop  = 1'b1;
                    hold_d    = fifo_rd_data;
                    tx_byte_d = fifo_rd_data[DATA_W-1:BYTE_W];
                    tx_hi_d   = 1'b1;
                    sel_d     = 1'b1;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                tx_req_d = 1'b1;
                state_d  = ST_REQ;
            end
            ST_REQ: begin
                if (ack_s) begin
                    tx_req_d = 1'b0;
                    state_d  = ST_REL;
                end
            end
            ST_REL: begin
                if (!ack_s) begin
                    if (sel_q) begin
                        tx_byte_d = hold_q[BYTE_W-1:0];
                        tx_hi_d   = 1'b0;
                        sel_d     = 1'b0;
                        state_d   = ST_SETUP;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tx_req_q   <= 1'b0;
            tx_byte_q  <= '0;
            tx_hi_q    <= 1'b0;
            sel_q      <= 1'b0;
            hold_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_req_q   <= tx_req_d;
            tx_byte_q  <= tx_byte_d;
            tx_hi_q    <= tx_hi_d;
            sel_q      <= sel_d;
            hold_q     <= hold_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_req    = tx_req_q;
    assign tx_byte   = tx_byte_q;
    assign tx_hi     = tx_hi_q;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule
